fetch_controller: RTL and testbench

- Drives the program counter's update interface (pc_write, pc_next) and consumes its current value (pc_in).
- Issues instruction-memory reads at the PC and presents fetched instructions to decode through a valid/ready output register.
- Handles decode back-pressure with a one-entry skid buffer.
- Handles branch redirects, including discarding an in-flight memory response that belongs to the old path.

---
 rtl/fetch_controller.sv | 134 +++++++++++++
 tb/tb_fetch_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives PC updates, issues imem reads, and presents
// fetched words to decode through a registered slot backed by a one-entry skid buffer.
module fetch_controller #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              dec_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [ADDR_W-1:0]   skid_pc_q;
  logic                slot_free;

  assign slot_free = !ir_valid || dec_ready;

  // PC update and memory request are decoded from the current state and strobes.
  always_comb begin
    pc_write  = 1'b0;
    pc_next   = '0;
    imem_req  = 1'b0;
    imem_addr = '0;
    unique case (state_q)
      StReq: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack) begin
          pc_write = 1'b1;
          pc_next  = pc_in + ADDR_W'(1);
        end
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
      end
      default: ;
    endcase
    // A redirect overrides any sequential increment, giving a single PC write.
    if (state_q != StIdle && branch_taken) begin
      pc_write = 1'b1;
      pc_next  = branch_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      ir_out      <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
    end else begin
      // Consumed slot empties unless a load below refills it.
      if (ir_valid && dec_ready) begin
        ir_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
        end
        StReq: begin
          addr_q <= pc_in;
          if (branch_taken) begin
            ir_valid    <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            // Without an ack the old request is still outstanding and must be drained.
            if (!imem_ack) begin
              state_q <= StDrain;
            end
          end else if (imem_ack) begin
            if (slot_free) begin
              ir_out   <= imem_rdata;
              ir_pc    <= pc_in;
              ir_valid <= 1'b1;
            end else begin
              skid_data_q <= imem_rdata;
              skid_pc_q   <= pc_in;
              state_q     <= StHold;
            end
          end
        end
        StHold: begin
          if (branch_taken) begin
            ir_valid    <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            state_q     <= StReq;
          end else if (dec_ready) begin
            ir_out      <= skid_data_q;
            ir_pc       <= skid_pc_q;
            ir_valid    <= 1'b1;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            state_q     <= StReq;
          end
        end
        StDrain: begin
          if (branch_taken) begin
            ir_valid    <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
          end
          if (imem_ack) begin
            state_q <= StReq;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller with a bench-side PC register
// and an address-derived instruction memory pattern.
module tb_fetch_controller;

  localparam logic [15:0] Key = 16'h5A00;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        pc_write;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        dec_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc_init;

  int checks;
  int errors;

  fetch_controller dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_write     (pc_write),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ir_out       (ir_out),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .dec_ready    (dec_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_in <= pc_init;
    else if (pc_write) pc_in <= pc_next;
  end

  assign imem_rdata = imem_addr ^ Key;

  typedef struct {
    logic        rst;
    logic [15:0] init;
    logic        ack;
    logic        dr;
    logic        br;
    logic [15:0] tgt;
    logic        pw;
    logic [15:0] pnext;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [15:0] init, logic ack, logic dr, logic br,
                              logic [15:0] tgt, logic pw, logic [15:0] pnext, logic req,
                              logic [15:0] addr, logic iv, logic [15:0] ipc);
    vec_t v;
    v.rst = rst; v.init = init; v.ack = ack; v.dr = dr; v.br = br; v.tgt = tgt;
    v.pw = pw; v.pnext = pnext; v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(int idx, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s got %h want %h", idx, name, act, exp);
    end
  endtask

  task automatic cyc(logic ack, logic dr, logic br, logic [15:0] tgt);
    @(negedge clk);
    imem_ack      = ack;
    dec_ready     = dr;
    branch_taken  = br;
    branch_target = tgt;
    #1;
  endtask

  task automatic do_reset(logic [15:0] init);
    @(negedge clk);
    pc_init = init;
    reset   = 1'b1;
    imem_ack = 1'b0; dec_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    pc_init = '0;
    imem_ack = 1'b0; dec_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // rst init ack dr br tgt | pw pnext req addr iv ipc
    // Zero-wait stream from PC 0, then a 3-cycle ack at 0x0004.
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0001, 1, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0001, 1, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0003, 1, 16'h0002, 1, 16'h0001));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0004, 1, 16'h0003, 1, 16'h0002));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0003));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0005, 1, 16'h0004, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0004));
    // Back-pressure at 0x0010: 0x0011 goes to skid, HOLD for 4 stalled cycles.
    vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0, 1, 16'h0011, 1, 16'h0010, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0, 1, 16'h0012, 1, 16'h0011, 1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0012, 1, 16'h0011));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0013, 1, 16'h0012, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0013, 1, 16'h0012));
    // Branch during outstanding request to 0x0020, then branch coincident with ack.
    vecs.push_back(mk(1, 16'h0020, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0100, 1, 16'h0100, 1, 16'h0020, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0101, 1, 16'h0100, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 16'h0200, 1, 16'h0200, 1, 16'h0101, 1, 16'h0100));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0201, 1, 16'h0200, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0201, 1, 16'h0200));
    // Branch ignored in IDLE; branch in HOLD flushes slot and skid.
    vecs.push_back(mk(1, 16'h0040, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0099, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0, 1, 16'h0041, 1, 16'h0040, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0, 1, 16'h0042, 1, 16'h0041, 1, 16'h0040));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0080, 1, 16'h0080, 0, 16'h0000, 1, 16'h0040));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h0081, 1, 16'h0080, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0000, 1, 16'h0081, 1, 16'h0080));

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) pc_init = vecs[i].init;
      reset         = vecs[i].rst;
      imem_ack      = vecs[i].ack;
      dec_ready     = vecs[i].dr;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      #1;
      chk(i, "pc_write", 32'(pc_write), 32'(vecs[i].pw));
      chk(i, "pc_next", 32'(pc_next), 32'(vecs[i].pnext));
      chk(i, "imem_req", 32'(imem_req), 32'(vecs[i].req));
      chk(i, "imem_addr", 32'(imem_addr), 32'(vecs[i].addr));
      chk(i, "ir_valid", 32'(ir_valid), 32'(vecs[i].iv));
      if (vecs[i].iv || vecs[i].rst) begin
        chk(i, "ir_pc", 32'(ir_pc), 32'(vecs[i].ipc));
        chk(i, "ir_out", 32'(ir_out), vecs[i].rst ? 32'h0 : 32'(vecs[i].ipc ^ Key));
      end
    end

    // PC wrap at 0xFFFF.
    do_reset(16'hFFFF);
    chk(100, "wrap_idle_req", 32'(imem_req), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    chk(101, "wrap_addr", 32'(imem_addr), 32'hFFFF);
    chk(101, "wrap_pc_write", 32'(pc_write), 32'h1);
    chk(101, "wrap_pc_next", 32'(pc_next), 32'h0000);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    chk(102, "wrap_ir_pc", 32'(ir_pc), 32'hFFFF);
    chk(102, "wrap_next_addr", 32'(imem_addr), 32'h0000);

    // Reset asserted mid-cycle while in HOLD.
    do_reset(16'h0030);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk(110, "hold_req", 32'(imem_req), 32'h0);
    chk(110, "hold_ir_valid", 32'(ir_valid), 32'h1);
    chk(110, "hold_ir_pc", 32'(ir_pc), 32'h0030);
    #1;
    reset = 1'b1;
    #1;
    chk(111, "rst_ir_valid", 32'(ir_valid), 32'h0);
    chk(111, "rst_imem_req", 32'(imem_req), 32'h0);
    chk(111, "rst_pc_write", 32'(pc_write), 32'h0);
    chk(111, "rst_ir_pc", 32'(ir_pc), 32'h0);
    chk(111, "rst_ir_out", 32'(ir_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
